hdng_err_gen: RTL and testbench

Heading-error generator feeding the PID controller. Converts each gyro-integrated heading sample into a 10-bit saturated signed error, `err_sat`, against a slew-limited internal target, and qualifies it with a one-cycle `err_vld` strobe. It primes the downstream P/I/D history with zero-error samples after motion starts, so the derivative term does not kick. It computes wrap-around-correct error on a 4096-count circle.

---
 rtl/hdng_pkg.sv | 27 ++
 rtl/hdng_slew.sv | 30 +++
 rtl/hdng_err_gen.sv | 106 ++++++++++
 tb/tb_hdng_err_gen.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/hdng_pkg.sv
// Shared types, widths and saturation helper for the heading-error generator.
package hdng_pkg;

    localparam int HDNG_W = 12;
    localparam int ERR_W  = 10;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        TRACK
    } state_e;

    localparam logic signed [HDNG_W-1:0] ERR_MAX = 12'sd511;
    localparam logic signed [HDNG_W-1:0] ERR_MIN = -12'sd512;

    // Clamp a signed 12-bit error into the signed 10-bit range.
    function automatic logic [ERR_W-1:0] sat12to10(input logic signed [HDNG_W-1:0] e);
        if (e > ERR_MAX) begin
            return 10'h1FF;
        end else if (e < ERR_MIN) begin
            return 10'h200;
        end else begin
            return e[ERR_W-1:0];
        end
    endfunction

endpackage

// File: rtl/hdng_slew.sv
// Next internal target: step toward the desired heading along the shortest
// path on the 4096-count circle, never more than SLEW_STEP per sample.
module hdng_slew
    import hdng_pkg::*;
#(
    parameter logic [HDNG_W-1:0] SLEW_STEP = 12'h010
) (
    input  logic [HDNG_W-1:0] tgt_hdng_i,
    input  logic [HDNG_W-1:0] dsrd_hdng_i,
    output logic [HDNG_W-1:0] tgt_nxt_o
);

    logic [HDNG_W-1:0] diff;
    logic [HDNG_W-1:0] diff_mag;

    assign diff     = dsrd_hdng_i - tgt_hdng_i;
    // Negating 0x800 yields 0x800, which reads correctly as magnitude 2048.
    assign diff_mag = diff[HDNG_W-1] ? (~diff + 12'd1) : diff;

    // NOTE: every output of a combinational block gets a value on every path,
    // otherwise synthesis infers a latch to hold the old one.
    always_comb begin
        tgt_nxt_o = dsrd_hdng_i;
        if (diff_mag > SLEW_STEP) begin
            tgt_nxt_o = diff[HDNG_W-1] ? (tgt_hdng_i - SLEW_STEP)
                                       : (tgt_hdng_i + SLEW_STEP);
        end
    end

endmodule

// File: rtl/hdng_err_gen.sv
// Heading-error generator: wrap-correct, saturated error against a slew-limited
// target, with a run of zero-error samples after each motion start.
module hdng_err_gen
    import hdng_pkg::*;
#(
    parameter logic [HDNG_W-1:0] SLEW_STEP    = 12'h010,
    parameter int unsigned       SETTLE_SMPLS = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [HDNG_W-1:0] dsrd_hdng,
    input  logic [HDNG_W-1:0] heading,
    input  logic              hdng_vld,
    input  logic              moving,
    output logic [ERR_W-1:0]  err_sat,
    output logic              err_vld,
    output logic              at_tgt
);

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_SMPLS - 1);

    state_e            state_q, state_d;
    logic [HDNG_W-1:0] tgt_hdng_q, tgt_hdng_d;
    logic [3:0]        settle_cnt_q, settle_cnt_d;
    logic [ERR_W-1:0]  err_sat_q, err_sat_d;
    logic              err_vld_q, err_vld_d;

    logic [HDNG_W-1:0] err_raw;
    logic [HDNG_W-1:0] tgt_slew;

    // Modulo-4096 subtraction gives the shortest-path error directly.
    assign err_raw = heading - tgt_hdng_q;

    hdng_slew #(
        .SLEW_STEP (SLEW_STEP)
    ) u_slew (
        .tgt_hdng_i  (tgt_hdng_q),
        .dsrd_hdng_i (dsrd_hdng),
        .tgt_nxt_o   (tgt_slew)
    );

    always_comb begin
        state_d      = state_q;
        tgt_hdng_d   = tgt_hdng_q;
        settle_cnt_d = settle_cnt_q;
        err_sat_d    = err_sat_q;
        err_vld_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (moving) begin
                    tgt_hdng_d   = heading;
                    settle_cnt_d = '0;
                    state_d      = SETTLE;
                end
            end
            SETTLE: begin
                if (!moving) begin
                    err_sat_d = '0;
                    state_d   = IDLE;
                end else if (hdng_vld) begin
                    err_sat_d    = '0;
                    err_vld_d    = 1'b1;
                    settle_cnt_d = settle_cnt_q + 4'd1;
                    if (settle_cnt_q == SETTLE_LAST) begin
                        state_d = TRACK;
                    end
                end
            end
            TRACK: begin
                if (!moving) begin
                    err_sat_d = '0;
                    state_d   = IDLE;
                end else if (hdng_vld) begin
                    // Error is taken against the pre-slew target.
                    err_sat_d  = sat12to10($signed(err_raw));
                    err_vld_d  = 1'b1;
                    tgt_hdng_d = tgt_slew;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            tgt_hdng_q   <= '0;
            settle_cnt_q <= '0;
            err_sat_q    <= '0;
            err_vld_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            tgt_hdng_q   <= tgt_hdng_d;
            settle_cnt_q <= settle_cnt_d;
            err_sat_q    <= err_sat_d;
            err_vld_q    <= err_vld_d;
        end
    end

    assign err_sat = err_sat_q;
    assign err_vld = err_vld_q;
    assign at_tgt  = (state_q == TRACK) && (tgt_hdng_q == dsrd_hdng);

endmodule

// File: tb/tb_hdng_err_gen.sv
// Randomized, scoreboarded bench for hdng_err_gen against an arithmetic model
// of the heading-error rules.
module tb_hdng_err_gen;

    localparam int STEP   = 16;
    localparam int SETTLE = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] dsrd_hdng = '0;
    logic [11:0] heading = '0;
    logic        hdng_vld = 1'b0;
    logic        moving = 1'b0;
    logic [9:0]  err_sat;
    logic        err_vld;
    logic        at_tgt;

    hdng_err_gen #(
        .SLEW_STEP    (12'(STEP)),
        .SETTLE_SMPLS (SETTLE)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .dsrd_hdng (dsrd_hdng),
        .heading   (heading),
        .hdng_vld  (hdng_vld),
        .moving    (moving),
        .err_sat   (err_sat),
        .err_vld   (err_vld),
        .at_tgt    (at_tgt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_q[$];

    // Reference model: motion flag, zero samples still owed, target, last error.
    bit m_active = 0;
    int m_zeros  = 0;
    int m_tgt    = 0;
    int m_err    = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic int wrap(input int x);
        return ((x % 4096) + 4096) % 4096;
    endfunction

    function automatic int signed_circ(input int x);
        int w;
        w = wrap(x);
        return (w >= 2048) ? w - 4096 : w;
    endfunction

    // Apply the rules for the edge that follows, using the current inputs.
    task automatic model_step();
        int e, d;
        if (!m_active) begin
            if (moving) begin
                m_active = 1;
                m_zeros  = SETTLE;
                m_tgt    = int'(heading);
            end
        end else if (!moving) begin
            m_active = 0;
            m_err    = 0;
        end else if (hdng_vld) begin
            if (m_zeros > 0) begin
                m_zeros--;
                m_err = 0;
            end else begin
                e = signed_circ(int'(heading) - m_tgt);
                m_err = (e > 511) ? 511 : (e < -512) ? -512 : e;
                d = signed_circ(int'(dsrd_hdng) - m_tgt);
                if ((d < 0 ? -d : d) <= STEP) m_tgt = int'(dsrd_hdng);
                else m_tgt = wrap(m_tgt + (d < 0 ? -STEP : STEP));
            end
            exp_q.push_back(m_err);
        end
    endtask

    task automatic cycle(input bit vld, input bit mv, input int h, input int d);
        hdng_vld  = vld;
        moving    = mv;
        heading   = 12'(h);
        dsrd_hdng = 12'(d);
        model_step();
        @(posedge clk);
        #1;
        check("err_sat_level", int'($signed(err_sat)), m_err);
        check("at_tgt", int'(at_tgt),
              int'(m_active && m_zeros == 0 && m_tgt == int'(dsrd_hdng)));
    endtask

    // Monitor: every strobe must match the oldest expected error.
    always @(negedge clk) begin
        if (err_vld) begin
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", 1, 0);
            end else begin
                check("strobe_err_sat", int'($signed(err_sat)), exp_q.pop_front());
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        int h, d;
        #12;
        check("reset_err_sat", int'(err_sat), 0);
        check("reset_err_vld", int'(err_vld), 0);
        check("reset_at_tgt", int'(at_tgt), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Motion start: the same-cycle sample is ignored, 4 zero strobes, then track.
        cycle(1, 1, 12'h100, 12'h100);
        for (int i = 0; i < 6; i++) cycle(1, 1, 12'h100, 12'h100);
        cycle(0, 0, 12'h100, 12'h100);

        // Wrap-around and saturation around a target of 0x7F0.
        cycle(0, 1, 12'h7F0, 12'h7F0);
        for (int i = 0; i < SETTLE; i++) cycle(1, 1, 12'h7F0, 12'h7F0);
        cycle(1, 1, 12'h810, 12'h7F0);
        cycle(1, 1, 12'hAF0, 12'h7F0);
        cycle(0, 1, 12'hAF0, 12'h7F0);
        cycle(1, 1, 12'h4F0, 12'h7F0);

        // Stop in the same cycle as a sample: no strobe, error cleared.
        cycle(1, 0, 12'h500, 12'h7F0);
        cycle(1, 0, 12'h500, 12'h7F0);

        // Slew from 0 toward 0x035, then the d = -2048 direction case.
        cycle(0, 1, 0, 0);
        for (int i = 0; i < SETTLE; i++) cycle(1, 1, 0, 0);
        for (int i = 0; i < 5; i++) cycle(1, 1, 0, 12'h035);
        check("slew_tgt_model", m_tgt, 12'h035);
        cycle(1, 1, 12'h035, 12'h835);
        check("slew_neg_half", m_tgt, 12'h025);
        cycle(0, 0, 0, 0);

        // Randomized traffic, including restarts and desired-heading changes.
        d = $urandom_range(0, 4095);
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) == 0) d = $urandom_range(0, 4095);
            else if ($urandom_range(0, 4) == 0) d = wrap(m_tgt + int'($urandom_range(0, 64)) - 32);
            if ($urandom_range(0, 1) == 0) h = $urandom_range(0, 4095);
            else h = wrap(m_tgt + int'($urandom_range(0, 1400)) - 700);
            cycle($urandom_range(0, 1), m_active ? ($urandom_range(0, 39) != 0)
                                                 : ($urandom_range(0, 1) == 1), h, d);
        end

        // Asynchronous reset while a TRACK strobe is on the output.
        cycle(0, 0, 0, 0);
        cycle(0, 1, 12'h200, 12'h300);
        for (int i = 0; i < SETTLE; i++) cycle(1, 1, 12'h200, 12'h300);
        cycle(1, 1, 12'h210, 12'h300);
        cycle(1, 1, 12'h240, 12'h300);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_err_vld", int'(err_vld), 0);
        check("async_rst_err_sat", int'(err_sat), 0);
        check("async_rst_at_tgt", int'(at_tgt), 0);
        exp_q.delete();
        m_active = 0;
        m_zeros  = 0;
        m_tgt    = 0;
        m_err    = 0;
        hdng_vld = 1'b0;
        moving   = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // After release the block must be idle: samples ignored until a start.
        cycle(1, 0, 12'h123, 12'h123);
        cycle(0, 1, 12'h123, 12'h123);
        for (int i = 0; i < SETTLE + 2; i++) cycle(1, 1, 12'h133, 12'h123);

        hdng_vld = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
